pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Owns the fetch PC register and decides its next value every cycle.
//   Arbitrates the redirect sources JR, J and conditional branch, and tracks stalls.
//   Holds one pending redirect while fetch is stalled.
//   Sequences the post-redirect IF/ID flush window and the terminal HALT state.
//   Sits between the EX-stage branch/jump resolution and the instruction fetch port.
// PARAMETERS
//   PC_INIT       32'h0000_0000  PC value loaded on reset
//   FLUSH_CYCLES  1              cycles flush is held after a redirect; legal 1..3
//   CNT_W         16             width of the redirect performance counter
// PORTS
//   CLK            in   1      clock, all state updates on rising edge
//   RST            in   1      synchronous reset, active-high
//   pcenable       in   1      1 = fetch may advance; 0 = stall, hold PC
//   halt           in   1      halt instruction retired; freezes PC until reset
//   beq            in   1      BEQ in EX
//   bne            in   1      BNE in EX
//   zero           in   1      ALU zero flag for the branch in EX
//   brstart        in   32     PC+4 of the branch/jump in EX
//   brval          in   32     sign-extended branch offset (words)
//   jsig           in   1      J/JAL in EX
//   jumpval        in   32     jump field; bits [25:0] used
//   jrsig          in   1      JR in EX
//   jrval          in   32     JR target register value
//   ladd           out  32     current fetch address
//   flush          out  1      squash IF/ID contents
//   redirect_taken out  1      1-cycle pulse: ladd just loaded a redirect target
//   halted         out  1      sequencer in HALTED state
//   redirect_cnt   out  CNT_W  count of applied redirects, saturating
// BEHAVIOUR
//   Reset (RST=1 at edge):
//     - Values: ladd=PC_INIT; flush=0; redirect_taken=0; halted=0; redirect_cnt=0.
//     - State RUN; pending cleared.
//     - RST overrides every other input, including mid-FLUSH and HALTED.
//   Redirect detection:
//     - taken = jrsig | jsig | (beq & zero) | (bne & ~zero).
//   Target priority:
//     - JR: jrval.
//     - else J: {brstart[31:28], jumpval[25:0], 2'b00}.
//     - else branch: brstart + (brval << 2).
//     - All arithmetic is 32-bit and wraps mod 2^32; ladd+4 at 32'hFFFF_FFFC gives 0.
//   States: RUN, FLUSH, HALTED.
//   halt=1 in any non-reset cycle:
//     - Next state HALTED; ladd holds; pending dropped.
//     - flush=0 and redirect_taken=0 next cycle; halted=1.
//     - Only RST exits HALTED; halt beats a simultaneous redirect.
//   RUN, pcenable=1:
//     - taken: ladd<=target; redirect_taken=1; cnt+=1; state FLUSH; pending cleared.
//     - else pending valid: ladd<=pending target, same actions as taken.
//     - else: ladd<=ladd+4.
//     - A new redirect overrides a pending one.
//   RUN, pcenable=0:
//     - ladd holds.
//     - taken latches its target into pending, overwriting any older pending.
//   FLUSH:
//     - flush=1 (registered, Moore) for exactly FLUSH_CYCLES cycles, counted regardless of pcenable.
//     - ladd advances +4 only when pcenable=1.
//     - Redirect inputs are ignored (wrong-path) and are not latched.
//     - Then returns to RUN.
//   Latency:
//     - Redirect sampled at edge N gives ladd=target and redirect_taken=1 from N+1.
//     - flush=1 from N+1 through N+FLUSH_CYCLES.
//   redirect_cnt saturates at all-ones and does not wrap.
//   Outputs are registered; no combinational input-to-output path.
// TESTING
//   1. Reset, pcenable=1, no redirects for 4 cycles -> ladd 0,4,8,C,10; flush=0.
//   2. brstart=0x100, brval=0xFFFF_FFFE, beq=1, zero=1:
//      -> ladd=0xF8 next cycle; redirect_taken 1 cycle; flush 1 cycle (FLUSH_CYCLES=1).
//   3. jrsig=1, jsig=1, jrval=0x400 together -> ladd=0x400 (JR wins); redirect_cnt=1.
//   4. pcenable=0, jsig=1, brstart=0x1000_0010, jumpval=0x40 for 1 cycle; then jsig=0, pcenable=0 for 2 more cycles:
//      -> ladd held throughout the stall.
//      -> After pcenable=1, ladd=0x1000_0100.
//   5. halt=1 coincident with bne=1, zero=0:
//      -> halted=1, ladd frozen for 10 cycles, redirect_cnt unchanged.
//      -> RST then returns ladd=PC_INIT, halted=0.
//   6. ladd=0xFFFF_FFFC, pcenable=1 -> ladd=0.
//      Force 2^CNT_W+1 redirects -> redirect_cnt stays all-ones.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch PC register with JR/J/branch redirect arbitration, one pending
// redirect held across stalls, a post-redirect flush window and HALT.
module pc_sequencer #(
    parameter logic [31:0] PC_INIT      = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pcenable,
    input  logic             halt,
    input  logic             beq,
    input  logic             bne,
    input  logic             zero,
    input  logic [31:0]      brstart,
    input  logic [31:0]      brval,
    input  logic             jsig,
    input  logic [31:0]      jumpval,
    input  logic             jrsig,
    input  logic [31:0]      jrval,
    output logic [31:0]      ladd,
    output logic             flush,
    output logic             redirect_taken,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_HALTED
    } state_e;

    localparam logic [1:0] FC_LAST = 2'(FLUSH_CYCLES - 1);

    state_e             state_q, state_d;
    logic [31:0]        ladd_q, ladd_d;
    logic               flush_q, flush_d;
    logic               rt_q, rt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_v_q, pend_v_d;
    logic [31:0]        pend_t_q, pend_t_d;
    logic [1:0]         fcnt_q, fcnt_d;

    logic               taken;
    logic [31:0]        target;
    logic [31:0]        ladd_inc;
    logic               cnt_inc;
    logic               unused_jump_hi;

    assign unused_jump_hi = ^jumpval[31:26];

    assign taken    = jrsig | jsig | (beq & zero) | (bne & ~zero);
    assign ladd_inc = ladd_q + 32'd4;

    always_comb begin
        target = brstart + (brval << 2);
        if (jrsig) begin
            target = jrval;
        end else if (jsig) begin
            target = {brstart[31:28], jumpval[25:0], 2'b00};
        end
    end

    always_comb begin
        state_d  = state_q;
        ladd_d   = ladd_q;
        flush_d  = flush_q;
        rt_d     = 1'b0;
        pend_v_d = pend_v_q;
        pend_t_d = pend_t_q;
        fcnt_d   = fcnt_q;
        cnt_inc  = 1'b0;
        if (halt) begin
            state_d  = S_HALTED;
            pend_v_d = 1'b0;
            flush_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (pcenable) begin
                        if (taken || pend_v_q) begin
                            ladd_d   = taken ? target : pend_t_q;
                            rt_d     = 1'b1;
                            cnt_inc  = 1'b1;
                            state_d  = S_FLUSH;
                            flush_d  = 1'b1;
                            fcnt_d   = FC_LAST;
                            pend_v_d = 1'b0;
                        end else begin
                            ladd_d = ladd_inc;
                        end
                    end else if (taken) begin
                        pend_v_d = 1'b1;
                        pend_t_d = target;
                    end
                end
                S_FLUSH: begin
                    // redirects seen here come from wrong-path instructions
                    if (pcenable) begin
                        ladd_d = ladd_inc;
                    end
                    if (fcnt_q == 2'd0) begin
                        state_d = S_RUN;
                        flush_d = 1'b0;
                    end else begin
                        fcnt_d = fcnt_q - 2'd1;
                    end
                end
                S_HALTED: begin
                    flush_d = 1'b0;
                end
                default: begin
                    state_d = S_RUN;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_RUN;
            ladd_q   <= PC_INIT;
            flush_q  <= 1'b0;
            rt_q     <= 1'b0;
            cnt_q    <= '0;
            pend_v_q <= 1'b0;
            pend_t_q <= 32'h0;
            fcnt_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            ladd_q   <= ladd_d;
            flush_q  <= flush_d;
            rt_q     <= rt_d;
            cnt_q    <= cnt_d;
            pend_v_q <= pend_v_d;
            pend_t_q <= pend_t_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign ladd           = ladd_q;
    assign flush          = flush_q;
    assign redirect_taken = rt_q;
    assign halted         = (state_q == S_HALTED);
    assign redirect_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus stall, halt,
// wrap-around and counter-saturation sequences.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST, pcenable, halt, beq, bne, zero, jsig, jrsig;
    logic [31:0] brstart, brval, jumpval, jrval;
    logic [31:0] ladd, ladd3;
    logic        flush, rt, halted, flush3, rt3, halted3;
    logic [3:0]  cnt, cnt3;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    pc_sequencer #(.FLUSH_CYCLES(1), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .pcenable(pcenable), .halt(halt),
        .beq(beq), .bne(bne), .zero(zero), .brstart(brstart),
        .brval(brval), .jsig(jsig), .jumpval(jumpval), .jrsig(jrsig),
        .jrval(jrval), .ladd(ladd), .flush(flush),
        .redirect_taken(rt), .halted(halted), .redirect_cnt(cnt)
    );

    pc_sequencer #(.FLUSH_CYCLES(3), .CNT_W(4)) dut3 (
        .CLK(CLK), .RST(RST), .pcenable(pcenable), .halt(halt),
        .beq(beq), .bne(bne), .zero(zero), .brstart(brstart),
        .brval(brval), .jsig(jsig), .jumpval(jumpval), .jrsig(jrsig),
        .jrval(jrval), .ladd(ladd3), .flush(flush3),
        .redirect_taken(rt3), .halted(halted3), .redirect_cnt(cnt3)
    );

    typedef struct {
        logic [7:0]  c;   // rst pcen halt beq bne zero jsig jrsig
        logic [31:0] bs, bv, jv, jr;
        logic [31:0] e_ladd;
        logic [3:0]  e_o; // flush rt halted flush3
        logic [3:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(logic [7:0] c, logic [31:0] bs, logic [31:0] bv,
                                logic [31:0] jv, logic [31:0] jr,
                                logic [31:0] el, logic [3:0] eo, logic [3:0] ec);
        vec_t v;
        v.c = c; v.bs = bs; v.bv = bv; v.jv = jv; v.jr = jr;
        v.e_ladd = el; v.e_o = eo; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear();
        RST = 0; pcenable = 0; halt = 0; beq = 0; bne = 0; zero = 0;
        jsig = 0; jrsig = 0; brstart = 0; brval = 0; jumpval = 0; jrval = 0;
    endtask

    task automatic do_reset();
        clear();
        RST = 1;
        tick();
        RST = 0;
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = mk(8'b1000_0000, 0, 0, 0, 0, 32'h0, 4'b0000, 0);
        vecs[1]  = mk(8'b0100_0000, 0, 0, 0, 0, 32'h4, 4'b0000, 0);
        vecs[2]  = mk(8'b0100_0000, 0, 0, 0, 0, 32'h8, 4'b0000, 0);
        vecs[3]  = mk(8'b0100_0000, 0, 0, 0, 0, 32'hC, 4'b0000, 0);
        vecs[4]  = mk(8'b0100_0000, 0, 0, 0, 0, 32'h10, 4'b0000, 0);
        vecs[5]  = mk(8'b0101_0100, 32'h100, 32'hFFFF_FFFE, 0, 0, 32'hF8, 4'b1101, 1);
        vecs[6]  = mk(8'b0100_0000, 0, 0, 0, 0, 32'hFC, 4'b0001, 1);
        vecs[7]  = mk(8'b0100_0000, 0, 0, 0, 0, 32'h100, 4'b0001, 1);
        vecs[8]  = mk(8'b1000_0000, 0, 0, 0, 0, 32'h0, 4'b0000, 0);
        vecs[9]  = mk(8'b0100_0011, 0, 0, 32'h40, 32'h400, 32'h400, 4'b1101, 1);
        vecs[10] = mk(8'b0100_0000, 0, 0, 0, 0, 32'h404, 4'b0001, 1);
        vecs[11] = mk(8'b0100_0010, 0, 0, 32'h10, 0, 32'h40, 4'b1101, 2);
        vecs[12] = mk(8'b0100_0001, 0, 0, 0, 32'h800, 32'h44, 4'b0000, 2);
        vecs[13] = mk(8'b0100_0000, 0, 0, 0, 0, 32'h48, 4'b0000, 2);
        vecs[14] = mk(8'b0100_1100, 32'h200, 32'h3, 0, 0, 32'h4C, 4'b0000, 2);
        vecs[15] = mk(8'b0101_0000, 32'h200, 32'h3, 0, 0, 32'h50, 4'b0000, 2);
        vecs[16] = mk(8'b0100_1000, 32'h200, 32'h3, 0, 0, 32'h20C, 4'b1101, 3);
        vecs[17] = mk(8'b0000_0000, 0, 0, 0, 0, 32'h20C, 4'b0001, 3);

        clear();
        for (int i = 0; i < 18; i++) begin
            {RST, pcenable, halt, beq, bne, zero, jsig, jrsig} = vecs[i].c;
            brstart = vecs[i].bs; brval = vecs[i].bv;
            jumpval = vecs[i].jv; jrval = vecs[i].jr;
            tick();
            chk($sformatf("v%0d ladd", i), ladd, vecs[i].e_ladd);
            chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].e_o[3]));
            chk($sformatf("v%0d redirect_taken", i), 32'(rt), 32'(vecs[i].e_o[2]));
            chk($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].e_o[1]));
            chk($sformatf("v%0d flush_fc3", i), 32'(flush3), 32'(vecs[i].e_o[0]));
            chk($sformatf("v%0d redirect_cnt", i), 32'(cnt), 32'(vecs[i].e_cnt));
        end

        // stall with pending J, then pending overwrite and override
        do_reset();
        pcenable = 0; jsig = 1; brstart = 32'h1000_0010; jumpval = 32'h40;
        tick();
        chk("stall ladd0", ladd, 32'h0);
        chk("stall rt0", 32'(rt), 32'h0);
        jsig = 0;
        tick();
        chk("stall ladd1", ladd, 32'h0);
        tick();
        chk("stall ladd2", ladd, 32'h0);
        pcenable = 1;
        tick();
        chk("pend ladd", ladd, 32'h1000_0100);
        chk("pend rt", 32'(rt), 32'h1);
        chk("pend flush", 32'(flush), 32'h1);
        tick();
        chk("pend next", ladd, 32'h1000_0104);
        pcenable = 0; jsig = 1; brstart = 0; jumpval = 32'h20;
        tick();
        jsig = 0; jrsig = 1; jrval = 32'h300;
        tick();
        jrsig = 0; pcenable = 1;
        tick();
        chk("pend overwrite", ladd, 32'h300);
        tick();
        pcenable = 0; jsig = 1; jumpval = 32'h20;
        tick();
        pcenable = 1; jsig = 0; jrsig = 1; jrval = 32'h500;
        tick();
        chk("new beats pend", ladd, 32'h500);
        jrsig = 0;
        tick();
        tick();
        chk("pend dropped", ladd, 32'h508);
        chk("pend cnt", 32'(cnt), 32'h3);

        // halt beats a simultaneous taken branch, only reset exits
        do_reset();
        pcenable = 1;
        tick();
        halt = 1; bne = 1; zero = 0; brstart = 32'h200; brval = 32'h10;
        tick();
        chk("halt halted", 32'(halted), 32'h1);
        chk("halt ladd", ladd, 32'h4);
        chk("halt rt", 32'(rt), 32'h0);
        halt = 0; bne = 0;
        for (int i = 0; i < 10; i++) begin
            jrsig = i[0]; jrval = 32'h900;
            tick();
            chk($sformatf("halt hold %0d", i), {ladd[31:2], halted, flush}, {30'h1, 1'b1, 1'b0});
        end
        chk("halt cnt", 32'(cnt), 32'h0);
        jrsig = 0; RST = 1;
        tick();
        RST = 0;
        chk("unhalt ladd", ladd, 32'h0);
        chk("unhalt halted", 32'(halted), 32'h0);
        tick();
        chk("unhalt run", ladd, 32'h4);

        // PC wrap-around
        do_reset();
        pcenable = 1; jrsig = 1; jrval = 32'hFFFF_FFF8;
        tick();
        chk("wrap jr", ladd, 32'hFFFF_FFF8);
        jrsig = 0;
        tick();
        chk("wrap fc", ladd, 32'hFFFF_FFFC);
        tick();
        chk("wrap zero", ladd, 32'h0);

        // 2^CNT_W+1 redirects saturate the counter
        do_reset();
        pcenable = 1; jrsig = 1; jrval = 32'h40;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk($sformatf("sat cnt %0d", i), 32'(cnt), (i > 15) ? 32'd15 : 32'(i));
            tick();
        end
        clear();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
